// File: rtl/fetch_stage.sv
// PC generator and IF/ID register in front of a combinational imem.
// Optional FETCH_PERF_EN adds fetch and stall counters.
module fetch_stage #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc_addr,
    input  logic [31:0]     imem_instr,
    input  logic            imem_exc_en,
    input  logic [3:0]      imem_exc_code,
    input  logic [XLEN-1:0] imem_exc_val,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_exc_en,
    output logic [3:0]      out_exc_code,
    output logic [XLEN-1:0] out_exc_val,
    output logic            fetch_halted
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_stall_cnt
`endif
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic {
        RUN,
        HALT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] opc_q, opc_d;
    logic [31:0]     instr_q, instr_d;
    logic            exc_en_q, exc_en_d;
    logic [3:0]      exc_code_q, exc_code_d;
    logic [XLEN-1:0] exc_val_q, exc_val_d;

    logic slot_free;
    logic capture;
    logic misaligned;
    logic cap_exc;

    always_comb begin
        slot_free  = !valid_q || out_ready;
        capture    = (state_q == RUN) && slot_free && !redirect_en;
        misaligned = pc_q[1:0] != 2'b00;
        cap_exc    = misaligned || imem_exc_en;

        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        opc_d      = opc_q;
        instr_d    = instr_q;
        exc_en_d   = exc_en_q;
        exc_code_d = exc_code_q;
        exc_val_d  = exc_val_q;

        if (redirect_en) begin
            valid_d = 1'b0;
            pc_d    = redirect_pc;
            state_d = RUN;
        end else if (capture) begin
            valid_d = 1'b1;
            opc_d   = pc_q;
            // Misalignment wins; imem data is meaningless for such a PC.
            if (misaligned) begin
                instr_d    = NOP;
                exc_en_d   = 1'b1;
                exc_code_d = 4'd0;
                exc_val_d  = pc_q;
            end else if (imem_exc_en) begin
                instr_d    = NOP;
                exc_en_d   = 1'b1;
                exc_code_d = imem_exc_code;
                exc_val_d  = imem_exc_val;
            end else begin
                instr_d    = imem_instr;
                exc_en_d   = 1'b0;
                exc_code_d = 4'd0;
                exc_val_d  = '0;
            end
            if (cap_exc) begin
                state_d = HALT;
            end else begin
                pc_d = pc_q + XLEN'(4);
            end
        end else if (slot_free) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            opc_q      <= '0;
            instr_q    <= NOP;
            exc_en_q   <= 1'b0;
            exc_code_q <= 4'd0;
            exc_val_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            opc_q      <= opc_d;
            instr_q    <= instr_d;
            exc_en_q   <= exc_en_d;
            exc_code_q <= exc_code_d;
            exc_val_q  <= exc_val_d;
        end
    end

    assign pc_addr      = pc_q;
    assign out_valid    = valid_q;
    assign out_pc       = opc_q;
    assign out_instr    = instr_q;
    assign out_exc_en   = exc_en_q;
    assign out_exc_code = exc_code_q;
    assign out_exc_val  = exc_val_q;
    assign fetch_halted = (state_q == HALT);

`ifdef FETCH_PERF_EN
    logic [63:0] fetch_cnt_q, fetch_cnt_d;
    logic [63:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {63'd0, capture};
        stall_cnt_d = stall_cnt_q + {63'd0, valid_q && !out_ready};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage; entries predicted at capture,
// checked when decode accepts them.
module tb_fetch_stage;

    localparam int unsigned XLEN = 64;
    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  code;
        logic [63:0] val;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pc_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;
    logic        fetch_halted;
`ifdef FETCH_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    fetch_stage #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_addr      (pc_addr),
        .imem_instr   (imem_instr),
        .imem_exc_en  (imem_exc_en),
        .imem_exc_code(imem_exc_code),
        .imem_exc_val (imem_exc_val),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_exc_en   (out_exc_en),
        .out_exc_code (out_exc_code),
        .out_exc_val  (out_exc_val),
        .fetch_halted (fetch_halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        if (a == 64'h0) return 32'h00500093;
        if (a == 64'h4) return 32'h00100113;
        return {a[21:2], 12'h093};
    endfunction

    // imem: 2048 words, anything at or above 0x2000 faults with cause 1
    assign imem_instr    = word_at(pc_addr);
    assign imem_exc_en   = pc_addr >= 64'h2000;
    assign imem_exc_code = 4'd1;
    assign imem_exc_val  = pc_addr;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    ent_t        sb[$];
    logic [63:0] m_pc;
    logic        m_valid;
    logic        m_halt;
    logic [63:0] m_fetch;
    logic [63:0] m_stall;

    task automatic cycle(input logic rdy, input logic redir,
                         input logic [63:0] rpc, input logic rst);
        logic slot, cap;
        ent_t e, g;
        out_ready   = rdy;
        redirect_en = redir;
        redirect_pc = rpc;
        rst_n       = !rst;
        #1;
        if (!rst && m_valid && rdy) begin
            if (sb.size() == 0) begin
                check("sb_empty", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("ent_pc", out_pc, e.pc);
                check("ent_instr", {32'd0, out_instr}, {32'd0, e.instr});
                check("ent_exc_en", {63'd0, out_exc_en}, {63'd0, e.exc_en});
                check("ent_code", {60'd0, out_exc_code}, {60'd0, e.code});
                check("ent_val", out_exc_val, e.val);
            end
        end
        slot = !m_valid || rdy;
        cap  = !m_halt && slot && !redir;
        if (rst) begin
            sb.delete();
            m_pc = RST_PC; m_valid = 0; m_halt = 0;
            m_fetch = 0; m_stall = 0;
        end else begin
            if (m_valid && !rdy) m_stall++;
            if (redir) begin
                sb.delete();
                m_valid = 0; m_pc = rpc; m_halt = 0;
            end else if (cap) begin
                m_fetch++;
                g.pc = m_pc;
                if (m_pc[1:0] != 0) begin
                    g.instr = NOP; g.exc_en = 1; g.code = 0; g.val = m_pc;
                end else if (m_pc >= 64'h2000) begin
                    g.instr = NOP; g.exc_en = 1; g.code = 1; g.val = m_pc;
                end else begin
                    g.instr = word_at(m_pc); g.exc_en = 0;
                    g.code = 0; g.val = 0;
                end
                sb.push_back(g);
                m_valid = 1;
                if (g.exc_en) m_halt = 1;
                else m_pc = m_pc + 64'd4;
            end else if (slot) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        check("pc_addr", pc_addr, m_pc);
        check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        check("halted", {63'd0, fetch_halted}, {63'd0, m_halt});
`ifdef FETCH_PERF_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch);
        check("perf_stall", perf_stall_cnt, m_stall);
`endif
    endtask

    initial begin
        logic [63:0] a;
        rst_n = 0; out_ready = 1; redirect_en = 0; redirect_pc = 0;
        m_pc = 0; m_valid = 0; m_halt = 0; m_fetch = 0; m_stall = 0;
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check("rst_out_pc", out_pc, 64'h0);
        check("rst_instr", {32'd0, out_instr}, {32'd0, NOP});
        check("rst_exc", {63'd0, out_exc_en}, 64'd0);

        // first two words, then 3 cycles of backpressure on pc 4
        cycle(1, 0, 0, 0);
        check("first_pc", out_pc, 64'h0);
        check("first_instr", {32'd0, out_instr}, 64'h00500093);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            check("stall_pc", out_pc, 64'h4);
            check("stall_instr", {32'd0, out_instr}, 64'h00100113);
        end
`ifdef FETCH_PERF_EN
        check("stall_cnt3", perf_stall_cnt, 64'd3);
`endif
        cycle(1, 0, 0, 0);
        check("after_stall_pc", out_pc, 64'h8);

        // redirect while backpressured
        cycle(0, 0, 0, 0);
        cycle(0, 1, 64'h100, 0);
        check("redir_valid", {63'd0, out_valid}, 64'd0);
        cycle(1, 0, 0, 0);
        check("redir_pc", out_pc, 64'h100);
        cycle(1, 0, 0, 0);

        // run off the end of imem
        cycle(1, 1, 64'h1FF8, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        check("fault_halt", {63'd0, fetch_halted}, 64'd1);
        check("fault_pc", pc_addr, 64'h2000);
        for (int i = 0; i < 3; i++) cycle(i[0], 0, 0, 0);

        // misaligned target, then resume
        cycle(1, 1, 64'h102, 0);
        cycle(0, 0, 0, 0);
        check("mis_code", {60'd0, out_exc_code}, 64'd0);
        check("mis_val", out_exc_val, 64'h102);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 64'h200, 0);
        cycle(1, 0, 0, 0);
        check("resume_pc", out_pc, 64'h200);

        // random traffic with occasional redirects
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = {50'd0, 14'($urandom_range(0, 16'h3FFF))};
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                cycle($urandom_range(0, 1) != 0, 1, a, 0);
            end else begin
                cycle($urandom_range(0, 3) != 0, 0, 0, 0);
            end
        end

        // reset mid-stream with a simultaneous redirect
        cycle(0, 0, 0, 0);
        cycle(1, 1, 64'h300, 1);
        check("mrst_valid", {63'd0, out_valid}, 64'd0);
        check("mrst_pc", pc_addr, RST_PC);
        check("mrst_instr", {32'd0, out_instr}, {32'd0, NOP});
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
